matmul_sequencer: RTL

Protocol sequencer for the UART matrix-multiply datapath. It parses the size byte, clears the operand memories and loads matrices A and B from the UART receiver. It then triggers the Calculator, captures the result, and serialises it byte by byte to the UART transmitter. It sits between uart_rx/uart_tx, the two matrix memories and the Calculator, and runs entirely on bclk.

---
 rtl/matmul_sequencer_if.sv | 36 +++
 rtl/matmul_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer_if.sv
// Signal bundle between the matmul sequencer and its UART, memory and
// Calculator neighbours. The sequencer uses the master view; the
// surrounding logic (or a bench) uses the slave view.
interface matmul_sequencer_if #(
  parameter int MAX_N = 3,
  parameter int RES_W = 16
);
  logic [7:0]                   rx_data;
  logic                         rx_valid;
  logic                         tx_busy;
  logic                         tx_start;
  logic [7:0]                   tx_data;
  logic [3:0]                   mem_addr;
  logic [7:0]                   mem_wdata;
  logic                         mem_a_we;
  logic                         mem_b_we;
  logic                         mult_start;
  logic                         mult_done;
  logic [MAX_N*MAX_N*RES_W-1:0] mult_result;
  logic [2:0]                   state;
  logic [3:0]                   matrix_size;
  logic [1:0]                   err_code;
  logic                         done;

  modport master (
    input  rx_data, rx_valid, tx_busy, mult_done, mult_result,
    output tx_start, tx_data, mem_addr, mem_wdata, mem_a_we, mem_b_we,
           mult_start, state, matrix_size, err_code, done
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, mult_done, mult_result,
    input  tx_start, tx_data, mem_addr, mem_wdata, mem_a_we, mem_b_we,
           mult_start, state, matrix_size, err_code, done
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Protocol sequencer for the UART matrix-multiply datapath: parses the size
// byte, clears and loads the A/B operand memories, kicks the Calculator and
// streams the result back out, high byte first, through the UART transmitter.
module matmul_sequencer #(
  parameter int MAX_N   = 3,
  parameter int RES_W   = 16,
  parameter int TIMEOUT = 255
) (
  input logic                bclk,
  input logic                rst,
  matmul_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    LOAD_A  = 3'd2,
    LOAD_B  = 3'd3,
    COMPUTE = 3'd4,
    SEND    = 3'd5
  } state_e;

  localparam int NELEM = MAX_N * MAX_N;
  localparam int RW    = NELEM * RES_W;

  state_e          state_q, state_d;
  logic [3:0]      n_q, n_d;
  logic [1:0]      err_q, err_d;
  logic [3:0]      clr_q, clr_d;
  logic [3:0]      r_q, r_d;
  logic [3:0]      c_q, c_d;
  logic [15:0]     idle_q, idle_d;
  logic [RW-1:0]   shadow_q, shadow_d;
  logic            hi_q, hi_d;
  logic            guard_q, guard_d;
  logic            last_q, last_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            mult_start_q, mult_start_d;
  logic            done_q, done_d;
  logic            last_rc;
  logic            size_ok;

  // Row-major element index inside the MAX_N x MAX_N memory / result vector.
  function automatic logic [3:0] elem_addr(input logic [3:0] r, input logic [3:0] c);
    int a;
    a = int'(r) * MAX_N + int'(c);
    return a[3:0];
  endfunction

  // Pick the high or low byte of result element k from the shadow copy.
  function automatic logic [7:0] sel_byte(input logic [RW-1:0] res, input logic [3:0] k,
                                          input logic hi);
    logic [RES_W-1:0] e;
    e = res[int'(k)*RES_W +: RES_W];
    return hi ? e[15:8] : e[7:0];
  endfunction

  assign last_rc = (r_q == n_q - 4'd1) && (c_q == n_q - 4'd1);
  assign size_ok = (bus.rx_data != 8'd0) && (int'(bus.rx_data) <= MAX_N);

  // Memory port: registered sweep while clearing, direct from rx while loading.
  always_comb begin
    bus.mem_a_we  = 1'b0;
    bus.mem_b_we  = 1'b0;
    bus.mem_addr  = 4'd0;
    bus.mem_wdata = 8'd0;
    unique case (state_q)
      CLEAR: begin
        bus.mem_a_we = 1'b1;
        bus.mem_b_we = 1'b1;
        bus.mem_addr = clr_q;
      end
      LOAD_A: begin
        bus.mem_a_we  = bus.rx_valid;
        bus.mem_addr  = elem_addr(r_q, c_q);
        bus.mem_wdata = bus.rx_data;
      end
      LOAD_B: begin
        bus.mem_b_we  = bus.rx_valid;
        bus.mem_addr  = elem_addr(r_q, c_q);
        bus.mem_wdata = bus.rx_data;
      end
      default: ;
    endcase
  end

  // Next-state logic for the protocol FSM, its counters and registered outputs.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    err_d        = err_q;
    clr_d        = clr_q;
    r_d          = r_q;
    c_d          = c_q;
    idle_d       = idle_q;
    shadow_d     = shadow_q;
    hi_d         = hi_q;
    last_d       = last_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    mult_start_d = 1'b0;
    done_d       = 1'b0;
    guard_d      = tx_start_q;
    unique case (state_q)
      IDLE: begin
        if (bus.rx_valid) begin
          if (size_ok) begin
            n_d     = bus.rx_data[3:0];
            err_d   = 2'b00;
            clr_d   = 4'd0;
            state_d = CLEAR;
          end else begin
            err_d = 2'b01;
          end
        end
      end
      CLEAR: begin
        if (bus.rx_valid) err_d = 2'b11;
        if (clr_q == 4'(NELEM - 1)) begin
          state_d = LOAD_A;
          r_d     = 4'd0;
          c_d     = 4'd0;
          idle_d  = 16'd0;
        end else begin
          clr_d = clr_q + 4'd1;
        end
      end
      LOAD_A, LOAD_B: begin
        if (bus.rx_valid) begin
          idle_d = 16'd0;
          if (c_q == n_q - 4'd1) begin
            c_d = 4'd0;
            r_d = r_q + 4'd1;
          end else begin
            c_d = c_q + 4'd1;
          end
          if (last_rc) begin
            r_d = 4'd0;
            c_d = 4'd0;
            if (state_q == LOAD_A) begin
              state_d = LOAD_B;
            end else begin
              state_d      = COMPUTE;
              mult_start_d = 1'b1;
            end
          end
        end else if (TIMEOUT != 0) begin
          if (idle_q == 16'(TIMEOUT - 1)) begin
            err_d   = 2'b10;
            state_d = IDLE;
          end else begin
            idle_d = idle_q + 16'd1;
          end
        end
      end
      COMPUTE: begin
        if (bus.rx_valid) err_d = 2'b11;
        // mult_start_q marks the first COMPUTE cycle, where mult_done may be stale.
        if (!mult_start_q && bus.mult_done) begin
          shadow_d = bus.mult_result;
          state_d  = SEND;
          r_d      = 4'd0;
          c_d      = 4'd0;
          hi_d     = 1'b1;
          last_d   = 1'b0;
        end
      end
      SEND: begin
        if (bus.rx_valid) err_d = 2'b11;
        if (last_q) begin
          if (tx_start_q) begin
            done_d  = 1'b1;
            last_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (!bus.tx_busy && !tx_start_q && !guard_q) begin
          tx_start_d = 1'b1;
          tx_data_d  = sel_byte(shadow_q, elem_addr(r_q, c_q), hi_q);
          if (hi_q) begin
            hi_d = 1'b0;
          end else begin
            hi_d = 1'b1;
            if (last_rc) begin
              last_d = 1'b1;
            end else if (c_q == n_q - 4'd1) begin
              c_d = 4'd0;
              r_d = r_q + 4'd1;
            end else begin
              c_d = c_q + 4'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transfer in progress.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      n_q          <= 4'd0;
      err_q        <= 2'b00;
      clr_q        <= 4'd0;
      r_q          <= 4'd0;
      c_q          <= 4'd0;
      idle_q       <= 16'd0;
      shadow_q     <= '0;
      hi_q         <= 1'b0;
      guard_q      <= 1'b0;
      last_q       <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'd0;
      mult_start_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      err_q        <= err_d;
      clr_q        <= clr_d;
      r_q          <= r_d;
      c_q          <= c_d;
      idle_q       <= idle_d;
      shadow_q     <= shadow_d;
      hi_q         <= hi_d;
      guard_q      <= guard_d;
      last_q       <= last_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      mult_start_q <= mult_start_d;
      done_q       <= done_d;
    end
  end

  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.mult_start  = mult_start_q;
  assign bus.state       = state_q;
  assign bus.matrix_size = n_q;
  assign bus.err_code    = err_q;
  assign bus.done        = done_q;

endmodule
